// File: rtl/snake_pkg.sv
// Shared direction codes and helpers for the snake game input path.
package snake_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_RIGHT = 3'd2;
  localparam dir_t DIR_DOWN  = 3'd3;
  localparam dir_t DIR_LEFT  = 3'd4;
  localparam dir_t DIR_RESET = DIR_RIGHT;

  function automatic dir_t dir_opposite(input dir_t code);
    case (code)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_RIGHT: return DIR_LEFT;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One active-low push-button: 2-FF synchroniser, counting debouncer and
// press-edge detector.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             sample;
  logic [CNT_W-1:0] cnt;

  assign sample = ~sync_q2;

  // The press pulse is asserted in the cycle the level is about to rise, so
  // the arbiter acts on the same edge that flips the debounced level.
  assign press = ~level & sample & (cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchroniser stages as
      // distinct flops; blocking ones would collapse them into a single stage.
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_dir_input.sv
// Conditions both players' direction buttons and arbitrates them into move1/move2.
// Define SNAKE_DIR_QUEUE_EN for a 2-entry turn queue per player behind pending.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        up2,
  input  logic        down2,
  input  logic        left2,
  input  logic        right2,
  output logic [31:0] move1,
  output logic [31:0] move2,
  output logic        turn1,
  output logic        turn2
);

  // Per player, bit 0..3 = up, right, down, left, which is also priority order.
  logic [7:0] btn_n;
  logic [7:0] press;

  assign btn_n = {left2, down2, right2, up2, left, down, right, up};

  for (genvar i = 0; i < 8; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .clock(clock),
      .reset(reset),
      .btn_n(btn_n[i]),
      .level(),
      .press(press[i])
    );
  end

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [3:0] ev;
    logic       req_valid;
    dir_t       req_code;
    dir_t       cbase;
    dir_t       pending;
    dir_t       committed;
    logic       turn;

    assign ev    = press[p*4 +: 4];
    assign cbase = tick ? pending : committed;

    always_comb begin
      // NOTE: every path assigns req_code first, so no latch is inferred.
      req_code  = DIR_LEFT;
      req_valid = |ev;
      if (ev[0])      req_code = DIR_UP;
      else if (ev[1]) req_code = DIR_RIGHT;
      else if (ev[2]) req_code = DIR_DOWN;
    end

`ifdef SNAKE_DIR_QUEUE_EN
    dir_t       q [2];
    logic [1:0] q_cnt;
    dir_t       check_base;
    logic       push;
    logic       pop;

    assign check_base = (q_cnt != 2'd0) ? q[q_cnt[1]] : cbase;
    assign push = req_valid && (req_code != dir_opposite(check_base)) && (q_cnt != 2'd2);
    assign pop  = tick && (q_cnt != 2'd0);

    always_ff @(posedge clock) begin
      if (reset) begin
        // NOTE: queue storage is not reset; q_cnt alone marks entries valid.
        pending   <= DIR_RESET;
        committed <= DIR_RESET;
        turn      <= 1'b0;
        q_cnt     <= 2'd0;
      end else begin
        turn <= 1'b0;
        if (tick) committed <= pending;
        if (pop) begin
          pending <= q[0];
          turn    <= (q[0] != pending);
        end
        case ({push, pop})
          2'b10: begin
            q[q_cnt[0]] <= req_code;
            q_cnt       <= q_cnt + 2'd1;
          end
          2'b01: begin
            q[0]  <= q[1];
            q_cnt <= q_cnt - 2'd1;
          end
          2'b11: q[0] <= req_code;
          default: ;
        endcase
      end
    end
`else
    always_ff @(posedge clock) begin
      if (reset) begin
        pending   <= DIR_RESET;
        committed <= DIR_RESET;
        turn      <= 1'b0;
      end else begin
        turn <= 1'b0;
        if (tick) committed <= pending;
        // A reversal is judged against the direction the snake will really move in.
        if (req_valid && (req_code != dir_opposite(cbase))) begin
          pending <= req_code;
          turn    <= (req_code != pending);
        end
      end
    end
`endif
  end

  assign move1 = {29'd0, g_player[0].pending};
  assign move2 = {29'd0, g_player[1].pending};
  assign turn1 = g_player[0].turn;
  assign turn2 = g_player[1].turn;

endmodule
